// File: rtl/ncl_threshold_gates.sv
// ncl_threshold_gates
// Clocked bank of NCL threshold gates: TH12 (completion OR), TH22 (C-element
// data-rail latch, initialises to NULL) and TH22D (C-element that initialises
// to DATA). Every lane is independent; hysteresis lives in clocked registers.
module ncl_threshold_gates #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             init,
    input  logic [WIDTH-1:0] th12_a,
    input  logic [WIDTH-1:0] th12_b,
    output logic [WIDTH-1:0] th12_z,
    input  logic [WIDTH-1:0] th22_a,
    input  logic [WIDTH-1:0] th22_b,
    output logic [WIDTH-1:0] th22_z,
    input  logic [WIDTH-1:0] th22d_a,
    input  logic [WIDTH-1:0] th22d_b,
    output logic [WIDTH-1:0] th22d_z
);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_lane
            // Power-up values match the init values so outputs are never X,
            // even before the first init edge.
            logic th22_reg  = 1'b0;
            logic th22d_reg = 1'b1;
            logic th22_next;
            logic th22d_next;

            // TH12: threshold 1 of 2, no state, unaffected by init.
            assign th12_z[gi] = th12_a[gi] | th12_b[gi];

            // C-element rule for both hysteresis gates: agree-high sets,
            // agree-low clears, disagreement holds the current value.
            always_comb begin
                th22_next  = th22_reg;
                th22d_next = th22d_reg;
                if (th22_a[gi] && th22_b[gi]) begin
                    th22_next = 1'b1;
                end else if (!th22_a[gi] && !th22_b[gi]) begin
                    th22_next = 1'b0;
                end
                if (th22d_a[gi] && th22d_b[gi]) begin
                    th22d_next = 1'b1;
                end else if (!th22d_a[gi] && !th22d_b[gi]) begin
                    th22d_next = 1'b0;
                end
            end

            // State update; init wins over any set or clear on the same edge.
            always_ff @(posedge clk) begin
                if (init) begin
                    th22_reg  <= 1'b0;
                    th22d_reg <= 1'b1;
                end else begin
                    th22_reg  <= th22_next;
                    th22d_reg <= th22d_next;
                end
            end

            assign th22_z[gi]  = th22_reg;
            assign th22d_z[gi] = th22d_reg;
        end
    endgenerate

endmodule

// File: tb/tb_ncl_threshold_gates.sv
// Directed self-checking bench for ncl_threshold_gates at WIDTH = 4.
// Single-lane sequences are replicated across all four lanes.
module tb_ncl_threshold_gates;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             init = 1'b0;
    logic [WIDTH-1:0] th12_a = '0;
    logic [WIDTH-1:0] th12_b = '0;
    logic [WIDTH-1:0] th12_z;
    logic [WIDTH-1:0] th22_a = '0;
    logic [WIDTH-1:0] th22_b = '0;
    logic [WIDTH-1:0] th22_z;
    logic [WIDTH-1:0] th22d_a = '0;
    logic [WIDTH-1:0] th22d_b = '0;
    logic [WIDTH-1:0] th22d_z;

    int n_compared   = 0;
    int n_mismatched = 0;

    ncl_threshold_gates #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .init    (init),
        .th12_a  (th12_a),
        .th12_b  (th12_b),
        .th12_z  (th12_z),
        .th22_a  (th22_a),
        .th22_b  (th22_b),
        .th22_z  (th22_z),
        .th22d_a (th22d_a),
        .th22d_b (th22d_b),
        .th22d_z (th22d_z)
    );

    always #5 clk = ~clk;

    // Count one comparison and print one line for it.
    task automatic check(input string tag, input logic [WIDTH-1:0] observed,
                         input logic [WIDTH-1:0] expected);
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("FAIL %s: got %b, required %b", tag, observed, expected);
        end else begin
            $display("ok   %s: %b", tag, observed);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // TH22 single-lane sequence 00,10,11,01,00,01 and expected outputs.
    logic [1:0] seq22_ab [6] = '{2'b00, 2'b10, 2'b11, 2'b01, 2'b00, 2'b01};
    logic       seq22_z  [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    // TH22D sequence after init: 10,01,00,11.
    logic [1:0] seq22d_ab [4] = '{2'b10, 2'b01, 2'b00, 2'b11};
    logic       seq22d_z  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    // TH12 truth table.
    logic [1:0] seq12_ab [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
    logic       seq12_z  [4] = '{1'b0, 1'b1, 1'b1, 1'b1};

    initial begin
        logic [1:0] ab;

        // Power-up values before any init edge.
        #1;
        check("powerup_th22", th22_z, 4'b0000);
        check("powerup_th22d", th22d_z, 4'b1111);

        // Reset with all inputs at 1 for two edges.
        init = 1'b1;
        th12_a = '1; th12_b = '1;
        th22_a = '1; th22_b = '1;
        th22d_a = '1; th22d_b = '1;
        step();
        step();
        check("reset_th22", th22_z, 4'b0000);
        check("reset_th22d", th22d_z, 4'b1111);
        check("reset_th12", th12_z, 4'b1111);
        init = 1'b0;
        step();
        check("release_th22", th22_z, 4'b1111);
        check("release_th22d", th22d_z, 4'b1111);

        // TH22 set / hold / clear sequence.
        for (int i = 0; i < 6; i++) begin
            ab = seq22_ab[i];
            th22_a = {WIDTH{ab[1]}};
            th22_b = {WIDTH{ab[0]}};
            step();
            check($sformatf("th22_seq%0d_ab%b", i, ab), th22_z, {WIDTH{seq22_z[i]}});
        end

        // Hold for several cycles while inputs disagree.
        th22_a = '1; th22_b = '1;
        step();
        th22_a = '1; th22_b = '0;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("th22_hold%0d", i), th22_z, 4'b1111);
        end

        // TH22D from init, then its sequence.
        th22d_a = '0; th22d_b = '0;
        init = 1'b1;
        step();
        check("th22d_init", th22d_z, 4'b1111);
        init = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ab = seq22d_ab[i];
            th22d_a = {WIDTH{ab[1]}};
            th22d_b = {WIDTH{ab[0]}};
            step();
            check($sformatf("th22d_seq%0d_ab%b", i, ab), th22d_z, {WIDTH{seq22d_z[i]}});
        end

        // TH12 truth table, same cycle.
        for (int i = 0; i < 4; i++) begin
            ab = seq12_ab[i];
            th12_a = {WIDTH{ab[1]}};
            th12_b = {WIDTH{ab[0]}};
            #1;
            check($sformatf("th12_ab%b", ab), th12_z, {WIDTH{seq12_z[i]}});
        end
        th12_a = 4'b1100; th12_b = 4'b1010;
        #1;
        check("th12_mixed", th12_z, 4'b1110);

        // Init mid-operation: reach th22 = 1, th22d = 0 first.
        th22_a = '1; th22_b = '1;
        th22d_a = '0; th22d_b = '0;
        step();
        check("mid_pre_th22", th22_z, 4'b1111);
        check("mid_pre_th22d", th22d_z, 4'b0000);
        th22d_a = '1; th22d_b = '1;
        init = 1'b1;
        step();
        check("mid_init_th22", th22_z, 4'b0000);
        check("mid_init_th22d", th22d_z, 4'b1111);
        init = 1'b0;
        th22d_a = '0; th22d_b = '0;
        step();
        check("mid_release_th22", th22_z, 4'b1111);
        check("mid_release_th22d", th22d_z, 4'b0000);
        th22d_a = '1; th22d_b = '1;
        step();
        check("mid_set_th22d", th22d_z, 4'b1111);

        // Lane independence from reset.
        init = 1'b1;
        step();
        init = 1'b0;
        th22_a = 4'b1010; th22_b = 4'b1100;
        step();
        check("lanes_set", th22_z, 4'b1000);
        th22_a = 4'b0000; th22_b = 4'b0100;
        step();
        check("lanes_clear", th22_z, 4'b0000);
        // Mixed set / clear / hold across lanes from all ones.
        th22_a = '1; th22_b = '1;
        step();
        th22_a = 4'b1100; th22_b = 4'b0101;
        step();
        check("lanes_mixed", th22_z, 4'b1101);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    // Global time bound so the bench always terminates.
    initial begin
        #100000;
        n_mismatched++;
        $display("FAIL timeout: got no finish, required finish before 100000");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/ncl_threshold_gates.md
# ncl_threshold_gates

Clocked behavioural library of the NCL threshold gates TH12, TH22 and TH22D, packaged as one parameterised bank. Every lane is independent. The bank supplies the rail-level primitives for the two-rail pipeline components:
- TH22 is the data-rail latch.
- TH22D is the data-rail latch that initialises to DATA.
- TH12 is the completion OR.

The hysteresis of the threshold gates is held in registers on the single system clock, with synchronous initialisation.

## Interface
Parameters:
- WIDTH, default 1: number of independent lanes for each gate type.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- init  input  1  synchronous, active-high reset. Sampled on the rising edge of clk.
- th12_a  input  WIDTH  TH12 input A, per lane.
- th12_b  input  WIDTH  TH12 input B, per lane.
- th12_z  output  WIDTH  TH12 output, per lane.
- th22_a  input  WIDTH  TH22 input A, per lane.
- th22_b  input  WIDTH  TH22 input B, per lane.
- th22_z  output  WIDTH  TH22 output, per lane; registered.
- th22d_a  input  WIDTH  TH22D input A, per lane.
- th22d_b  input  WIDTH  TH22D input B, per lane.
- th22d_z  output  WIDTH  TH22D output, per lane; registered.

## Operation
TH12 (threshold 1 of 2, no hysteresis):
- th12_z[i] = th12_a[i] | th12_b[i].
- Purely combinational. init has no effect on it.

TH22 (threshold 2 of 2 with hysteresis, i.e. a C-element), per lane, at each rising clk edge:
- If init = 1: th22_z[i] <= 0.
- Else if a[i] = 1 and b[i] = 1: th22_z[i] <= 1 (assert DATA).
- Else if a[i] = 0 and b[i] = 0: th22_z[i] <= 0 (assert NULL).
- Else (inputs differ): th22_z[i] holds its current value.

TH22D (TH22 that initialises to 1):
- Same set, clear and hold rules as TH22.
- If init = 1: th22d_z[i] <= 1.

General rules:
- Lanes never interact. Each lane depends only on its own input bits.
- init has priority over the input conditions on the same edge.
- No X propagation on outputs after the first init edge.
- Power-up value before the first init edge: TH22 lanes 0, TH22D lanes 1. Implement this with register initialisers.

## Timing
- TH12: zero-cycle latency; combinational from input to output.
- TH22 and TH22D: one-cycle latency. Inputs sampled on edge k are visible on the output after edge k.
- Hold case: an output keeps its value for any number of cycles while the inputs disagree.
- Reset timing: an init pulse covering at least one rising edge forces the reset values, which appear after that edge.
- Release from init: on the first edge with init = 0, the normal set/clear/hold rules apply to the inputs present at that edge.
- init asserted mid-operation: overrides any pending set or clear on that edge. Example: TH22 with a = b = 1 and init = 1 gives output 0.
- Simultaneous events:
  - Both inputs changing from 0,0 to 1,1 within one cycle sets the output.
  - 1,1 to 0,0 clears it.
  - 0,1 to 1,0 holds.
- No other handshake. Completion (TH12 OR of the two rails) is left to the user's wiring.

## Test plan
- Reset values: init = 1 for 2 edges with all inputs at 1. Required: th22_z = 0, th22d_z = all ones, th12_z = all ones (combinational). After release with inputs held at 1,1: th22_z becomes all ones one edge later.
- TH22 sequence (WIDTH = 1): (a,b) = 00, 10, 11, 01, 00, 01, applied one per edge. Required th22_z after each edge: 0, 0, 1, 1, 0, 0.
- TH22D from init: after init the output is 1. Then (a,b) = 10, 01, 00, 11. Required th22d_z after each edge: 1, 1, 0, 1.
- TH12 truth table: (a,b) = 00, 01, 10, 11. Required th12_z = 0, 1, 1, 1 in the same cycle.
- Init mid-operation: TH22 and TH22D outputs at 1 and 0 respectively, inputs 1,1, then assert init for one edge. Required: th22_z = 0 and th22d_z = 1 after that edge. Next edge with init = 0: both outputs return to 1.
- Lane independence (WIDTH = 4): th22_a = 4'b1010, th22_b = 4'b1100 from the reset state. Required th22_z = 4'b1000. Then apply a = 4'b0000, b = 4'b0100. Required th22_z = 4'b0000.
